// File: rtl/cactus_scheduler_pkg.sv
// Shared game package: top-level game state, scheduler FSM encoding and
// defaults that the cactus mover and the scheduler must agree on.
package cactus_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WIN  = 2'd2,
    OVER = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNT     = 3'd1,
    S_STEP      = 3'd2,
    S_WAIT_DRAW = 3'd3,
    S_HALT      = 3'd4
  } sched_state_t;

  localparam int unsigned DEF_WRAP_PIXEL  = 321;
  localparam int unsigned DEF_BASE_PERIOD = 60000;

endpackage

// File: rtl/cactus_scheduler_period_calc.sv
// Step period from speed level: max(BASE - level*DEC, MIN), clamped before
// the subtraction can wrap.
module period_calc #(
  parameter int unsigned BASE_PERIOD = 60000,
  parameter int unsigned PERIOD_DEC  = 5000,
  parameter int unsigned MIN_PERIOD  = 20000
) (
  input  logic [2:0]  speed_level,
  output logic [31:0] period
);

  logic [31:0] dec;

  // Clamp decides on the decrement before subtracting, so no underflow.
  always_comb begin
    dec = {29'd0, speed_level} * PERIOD_DEC;
    if ((BASE_PERIOD <= MIN_PERIOD) || (dec >= (BASE_PERIOD - MIN_PERIOD))) begin
      period = MIN_PERIOD;
    end else begin
      period = BASE_PERIOD - dec;
    end
  end

endmodule

// File: rtl/cactus_scheduler.sv
// Cactus-movement scheduler: paces step strobes, waits for redraw, counts
// passed cacti, raises speed and the win request.
//
// state        | meaning
// S_IDLE       | game not running; counters, score, level, win cleared
// S_COUNT      | counting the step period
// S_STEP       | one-cycle step strobe (and spawn on wrap)
// S_WAIT_DRAW  | waiting for draw_done or the redraw timeout
// S_HALT       | game won/over; everything frozen
module cactus_scheduler
  import cactus_scheduler_pkg::*;
#(
  parameter int unsigned BASE_PERIOD  = DEF_BASE_PERIOD,
  parameter int unsigned PERIOD_DEC   = 5000,
  parameter int unsigned MIN_PERIOD   = 20000,
  parameter int unsigned LEVEL_EVERY  = 4,
  parameter int unsigned WIN_COUNT    = 50,
  parameter int unsigned WRAP_PIXEL   = DEF_WRAP_PIXEL,
  parameter int unsigned DRAW_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  state_t     game_state,
  input  logic [8:0] cactus_pixel,
  input  logic       draw_done,
  output logic       step_en,
  output logic       spawn,
  output logic [2:0] speed_level,
  output logic [7:0] passed_count,
  output logic       win_req,
  output logic       busy
);

  sched_state_t state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  tcnt_q, tcnt_d;
  logic [2:0]   level_q, level_d;
  logic [7:0]   passed_q, passed_d;
  logic         win_q, win_d;

  logic [31:0]  period;
  logic         wrap;
  logic [7:0]   passed_inc;

  period_calc #(
    .BASE_PERIOD (BASE_PERIOD),
    .PERIOD_DEC  (PERIOD_DEC),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_period_calc (
    .speed_level (level_q),
    .period      (period)
  );

  assign wrap       = ({23'd0, cactus_pixel} == WRAP_PIXEL);
  assign passed_inc = (passed_q == 8'hFF) ? 8'hFF : passed_q + 8'd1;

  // Next-state and counter logic; game_state overrides are applied last so
  // they win over any internal transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    level_d  = level_q;
    passed_d = passed_q;
    win_d    = win_q;

    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        tcnt_d   = '0;
        level_d  = '0;
        passed_d = '0;
        win_d    = 1'b0;
        if (game_state == RUN) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (cnt_q == period - 32'd1) begin
          cnt_d   = '0;
          state_d = S_STEP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_STEP: begin
        state_d = S_WAIT_DRAW;
        if (wrap) begin
          passed_d = passed_inc;
          if ((passed_inc != 8'd0) && (({24'd0, passed_inc} % LEVEL_EVERY) == 32'd0)
              && (level_q != 3'd7)) begin
            level_d = level_q + 3'd1;
          end
          if ({24'd0, passed_inc} == WIN_COUNT) win_d = 1'b1;
        end
      end
      S_WAIT_DRAW: begin
        if (draw_done || (tcnt_q == DRAW_TIMEOUT - 32'd1)) begin
          tcnt_d  = '0;
          state_d = S_COUNT;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
      S_HALT: begin
        if (game_state == RUN) begin
          cnt_d   = '0;
          tcnt_d  = '0;
          state_d = S_COUNT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (game_state)
      IDLE: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        tcnt_d   = '0;
        level_d  = '0;
        passed_d = '0;
        win_d    = 1'b0;
      end
      WIN, OVER: begin
        state_d  = S_HALT;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        level_d  = level_q;
        passed_d = passed_q;
        win_d    = win_q;
      end
      default: ;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      level_q  <= '0;
      passed_q <= '0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      level_q  <= level_d;
      passed_q <= passed_d;
      win_q    <= win_d;
    end
  end

  assign step_en      = (state_q == S_STEP);
  assign spawn        = step_en && wrap;
  assign busy         = (state_q == S_WAIT_DRAW);
  assign speed_level  = level_q;
  assign passed_count = passed_q;
  assign win_req      = win_q;

endmodule

// File: tb/tb_cactus_scheduler.sv
// Directed bench for cactus_scheduler with small test parameters.
module tb_cactus_scheduler;
  import cactus_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  state_t     game_state;
  logic [8:0] cactus_pixel;
  logic       draw_done;
  logic       step_en, spawn, win_req, busy;
  logic [2:0] speed_level;
  logic [7:0] passed_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int gap;     // ticks from previous reference sample to step_en
    int passed;  // passed_count after the step
    int level;   // speed_level after the step
    int win;     // win_req after the step
  } vec_t;

  vec_t vecs[9];

  cactus_scheduler #(
    .BASE_PERIOD  (20),
    .PERIOD_DEC   (4),
    .MIN_PERIOD   (8),
    .LEVEL_EVERY  (2),
    .WIN_COUNT    (5),
    .WRAP_PIXEL   (321),
    .DRAW_TIMEOUT (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_state   (game_state),
    .cactus_pixel (cactus_pixel),
    .draw_done    (draw_done),
    .step_en      (step_en),
    .spawn        (spawn),
    .speed_level  (speed_level),
    .passed_count (passed_count),
    .win_req      (win_req),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Ticks until step_en is seen; n = -1 when the bound expires.
  task automatic wait_step(output int n);
    logic found;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      tick();
      n++;
      found = step_en;
    end
    if (!found) n = -1;
  endtask

  // From the S_STEP sample: return draw_done in the third wait cycle.
  task automatic draw_resp;
    tick();
    tick();
    tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
  endtask

  initial begin
    int n, m, nb, stepped, prev_passed;

    // First gap includes the edge that leaves S_IDLE.
    vecs[0] = '{21, 1, 0, 0};
    vecs[1] = '{20, 2, 1, 0};
    vecs[2] = '{16, 3, 1, 0};
    vecs[3] = '{16, 4, 2, 0};
    vecs[4] = '{12, 5, 2, 1};
    vecs[5] = '{12, 6, 3, 1};
    vecs[6] = '{ 8, 7, 3, 1};
    vecs[7] = '{ 8, 8, 4, 1};
    vecs[8] = '{ 8, 9, 4, 1};

    rst          = 1'b1;
    game_state   = IDLE;
    cactus_pixel = 9'd321;
    draw_done    = 1'b0;
    repeat (3) tick();

    check("reset step_en", int'(step_en), 0);
    check("reset spawn", int'(spawn), 0);
    check("reset busy", int'(busy), 0);
    check("reset passed", int'(passed_count), 0);
    check("reset level", int'(speed_level), 0);
    check("reset win", int'(win_req), 0);

    rst = 1'b0;
    tick();
    game_state = RUN;

    prev_passed = 0;
    for (int k = 0; k < 9; k++) begin
      wait_step(n);
      check($sformatf("step%0d gap", k), n, vecs[k].gap);
      check($sformatf("step%0d spawn", k), int'(spawn), 1);
      check($sformatf("step%0d passed_pre", k), int'(passed_count), prev_passed);
      tick();
      check($sformatf("step%0d busy", k), int'(busy), 1);
      check($sformatf("step%0d passed", k), int'(passed_count), vecs[k].passed);
      check($sformatf("step%0d level", k), int'(speed_level), vecs[k].level);
      check($sformatf("step%0d win", k), int'(win_req), vecs[k].win);
      tick();
      tick();
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      check($sformatf("step%0d busy_after", k), int'(busy), 0);
      prev_passed = vecs[k].passed;
    end

    // Draw timeout: no draw_done, no wrap.
    cactus_pixel = 9'd0;
    wait_step(n);
    check("timeout gap", n, 8);
    check("no-wrap spawn", int'(spawn), 0);
    nb = 0;
    tick();
    while (busy && nb < 20) begin
      nb++;
      tick();
    end
    check("timeout busy cycles", nb, 6);
    check("no-wrap passed", int'(passed_count), 9);

    // draw_done during S_COUNT must not shorten the period.
    tick();
    tick();
    tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    wait_step(m);
    check("stray draw_done gap", (m < 0) ? -1 : 4 + m, 8);
    draw_resp();

    // Halt mid-count, then resume.
    tick();
    tick();
    tick();
    game_state = OVER;
    stepped = 0;
    repeat (50) begin
      tick();
      if (step_en) stepped++;
    end
    check("halt steps", stepped, 0);
    check("halt passed", int'(passed_count), 9);
    check("halt level", int'(speed_level), 4);
    check("halt busy", int'(busy), 0);
    game_state = RUN;
    wait_step(n);
    check("resume gap", n, 9);
    draw_resp();

    // IDLE clears score, level and win.
    check("win before idle", int'(win_req), 1);
    game_state = IDLE;
    tick();
    check("idle win", int'(win_req), 0);
    check("idle passed", int'(passed_count), 0);
    check("idle level", int'(speed_level), 0);

    // Reset in the middle of a redraw wait.
    cactus_pixel = 9'd321;
    game_state = RUN;
    wait_step(n);
    check("restart gap", n, 21);
    tick();
    check("pre-rst busy", int'(busy), 1);
    check("pre-rst passed", int'(passed_count), 1);
    rst = 1'b1;
    #1;
    check("rst busy", int'(busy), 0);
    check("rst step_en", int'(step_en), 0);
    check("rst spawn", int'(spawn), 0);
    check("rst passed", int'(passed_count), 0);
    check("rst level", int'(speed_level), 0);
    check("rst win", int'(win_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
